// File: rtl/mdu_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// mdu_sequencer_pkg
// Shared definitions for the MDU sequencer. It contains the R-type opcode, the
// HI/LO-class funct codes and the sequencer state encoding. Every decode in
// mdu_sequencer uses these names, so the file has no local magic numbers.
// -----------------------------------------------------------------------------
package mdu_sequencer_pkg;

    // R-type opcode and the funct codes of the HI/LO-class instructions
    localparam logic [5:0] IRTYPE = 6'b000000;
    localparam logic [5:0] FMFHI  = 6'h10;
    localparam logic [5:0] FMTHI  = 6'h11;
    localparam logic [5:0] FMFLO  = 6'h12;
    localparam logic [5:0] FMTLO  = 6'h13;
    localparam logic [5:0] FMULT  = 6'h18;
    localparam logic [5:0] FMULTU = 6'h19;
    localparam logic [5:0] FDIV   = 6'h1A;
    localparam logic [5:0] FDIVU  = 6'h1B;

    typedef enum logic [1:0] {
        SIDLE = 2'd0,
        SBUSY = 2'd1,
        SDONE = 2'd2
    } mdu_state_t;

endpackage

// File: rtl/mdu_sequencer.sv
// -----------------------------------------------------------------------------
// mdu_sequencer
// Launches MULT/MULTU/DIV/DIVU from the E stage and counts the fixed MDU
// latency. It pulses hilo_we when the result is ready. While the MDU or HI/LO
// is not yet available, it stalls any HI/LO-class instruction in E.
//
// Ports
//   clk, rst        pipeline clock, asynchronous active-high reset
//   E_valid         E slot holds a real instruction
//   E_op, E_funct   E-stage opcode / funct
//   F/D/E_stall     hold PC, IF/ID, ID/EX (ORed with load-use stalls outside)
//   M_bubble        insert a NOP into EX/MEM
//   mdu_start       one-cycle launch pulse; mdu_div / mdu_signed qualify it
//   hilo_we         one-cycle HI/LO write of the MDU result
//   busy            sequencer is not idle
// -----------------------------------------------------------------------------
module mdu_sequencer
    import mdu_sequencer_pkg::*;
#(
    parameter int MUL_LAT = 4,   // BUSY cycles for MULT/MULTU (1..63)
    parameter int DIV_LAT = 32   // BUSY cycles for DIV/DIVU  (1..63)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       E_valid,
    input  logic [5:0] E_op,
    input  logic [5:0] E_funct,
    output logic       F_stall,
    output logic       D_stall,
    output logic       E_stall,
    output logic       M_bubble,
    output logic       mdu_start,
    output logic       mdu_div,
    output logic       mdu_signed,
    output logic       hilo_we,
    output logic       busy
);

    localparam logic [5:0] MUL_CNT = 6'(MUL_LAT - 1);
    localparam logic [5:0] DIV_CNT = 6'(DIV_LAT - 1);

    mdu_state_t state;
    logic [5:0] cnt;

    logic is_hilo;     // any HI/LO-class instruction in E
    logic is_mdu;      // MULT/MULTU/DIV/DIVU in E
    logic dec_div;
    logic dec_signed;
    logic hazard;
    logic launch;

    // NOTE: every output of an always_comb gets a default first, so no path
    // leaves a value unassigned. Without the defaults a latch would be inferred.
    always_comb begin
        is_hilo    = 1'b0;
        is_mdu     = 1'b0;
        dec_div    = 1'b0;
        dec_signed = 1'b0;
        if (E_valid && E_op == IRTYPE) begin
            unique case (E_funct)
                FMULT:  begin is_hilo = 1'b1; is_mdu = 1'b1; dec_signed = 1'b1; end
                FMULTU: begin is_hilo = 1'b1; is_mdu = 1'b1; end
                FDIV:   begin is_hilo = 1'b1; is_mdu = 1'b1; dec_div = 1'b1; dec_signed = 1'b1; end
                FDIVU:  begin is_hilo = 1'b1; is_mdu = 1'b1; dec_div = 1'b1; end
                FMFHI, FMFLO, FMTHI, FMTLO: is_hilo = 1'b1;
                default: ;
            endcase
        end
    end

    // A launch is possible only from IDLE. Gating with rst keeps every output
    // at 0 while reset is held, even when E holds an MDU instruction.
    assign launch = (state == SIDLE) && is_mdu && !rst;
    assign hazard = (state != SIDLE) && is_hilo;

    assign F_stall    = hazard;
    assign D_stall    = hazard;
    assign E_stall    = hazard;
    assign M_bubble   = hazard;
    assign mdu_start  = launch;
    assign mdu_div    = launch && dec_div;
    assign mdu_signed = launch && dec_signed;
    assign hilo_we    = (state == SDONE);
    assign busy       = (state != SIDLE);

    // NOTE: sequential state uses non-blocking assignments, so all flops
    // sample their inputs from before the edge and update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= SIDLE;
            cnt   <= 6'd0;
        end else begin
            unique case (state)
                SIDLE: begin
                    if (launch) begin
                        state <= SBUSY;
                        cnt   <= dec_div ? DIV_CNT : MUL_CNT;
                    end
                end
                // cnt counts down from LAT-1, so BUSY lasts exactly LAT cycles
                SBUSY: begin
                    if (cnt == 6'd0) state <= SDONE;
                    else             cnt   <= cnt - 6'd1;
                end
                SDONE:   state <= SIDLE;
                default: state <= SIDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mdu_sequencer
// Directed scenarios with a randomized run. The random run is checked against
// a cycles-remaining model of the sequencer.
// The output vector layout is
//   {F_stall, D_stall, E_stall, M_bubble, mdu_start, mdu_div, mdu_signed, hilo_we, busy}
// -----------------------------------------------------------------------------
module tb_mdu_sequencer;

    localparam int MUL_LAT = 4;
    localparam int DIV_LAT = 32;

    localparam logic [5:0] OP_R   = 6'h00;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_SW  = 6'h2B;
    localparam logic [5:0] F_ADD  = 6'h20;
    localparam logic [5:0] F_MFHI = 6'h10;
    localparam logic [5:0] F_MTHI = 6'h11;
    localparam logic [5:0] F_MFLO = 6'h12;
    localparam logic [5:0] F_MTLO = 6'h13;
    localparam logic [5:0] F_MULT = 6'h18;
    localparam logic [5:0] F_MULTU= 6'h19;
    localparam logic [5:0] F_DIV  = 6'h1A;
    localparam logic [5:0] F_DIVU = 6'h1B;

    localparam logic [8:0] STALL4 = 9'b1111_0000_0;
    localparam logic [8:0] BUSY1  = 9'b0000_0000_1;
    localparam logic [8:0] HWE    = 9'b0000_0001_0;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       E_valid = 1'b0;
    logic [5:0] E_op = 6'h00;
    logic [5:0] E_funct = 6'h00;
    logic       F_stall, D_stall, E_stall, M_bubble;
    logic       mdu_start, mdu_div, mdu_signed, hilo_we, busy;

    int errors = 0;
    int checks = 0;

    mdu_sequencer #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk(clk), .rst(rst),
        .E_valid(E_valid), .E_op(E_op), .E_funct(E_funct),
        .F_stall(F_stall), .D_stall(D_stall), .E_stall(E_stall),
        .M_bubble(M_bubble), .mdu_start(mdu_start), .mdu_div(mdu_div),
        .mdu_signed(mdu_signed), .hilo_we(hilo_we), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [8:0] obs();
        return {F_stall, D_stall, E_stall, M_bubble, mdu_start, mdu_div, mdu_signed, hilo_we, busy};
    endfunction

    // One pipeline cycle: drive E after the falling edge, sample 1 ns later.
    task automatic drive(input logic v, input logic [5:0] op, input logic [5:0] f);
        @(negedge clk);
        E_valid = v;
        E_op    = op;
        E_funct = f;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        E_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // ---------------- reference model: cycles until sequencer is idle ----------
    int rem;

    function automatic bit m_hilo(input logic v, input logic [5:0] op, input logic [5:0] f);
        return v && op == OP_R &&
               (f == F_MULT || f == F_MULTU || f == F_DIV || f == F_DIVU ||
                f == F_MFHI || f == F_MFLO || f == F_MTHI || f == F_MTLO);
    endfunction

    function automatic bit m_mdu(input logic v, input logic [5:0] op, input logic [5:0] f);
        return v && op == OP_R && (f == F_MULT || f == F_MULTU || f == F_DIV || f == F_DIVU);
    endfunction

    function automatic logic [8:0] m_expect(input logic v, input logic [5:0] op, input logic [5:0] f);
        bit idle, stall, start;
        idle  = (rem == 0);
        stall = !idle && m_hilo(v, op, f);
        start = idle && m_mdu(v, op, f);
        return {stall, stall, stall, stall, start,
                start && (f == F_DIV || f == F_DIVU),
                start && (f == F_MULT || f == F_DIV),
                rem == 1, !idle};
    endfunction

    task automatic m_advance(input logic v, input logic [5:0] op, input logic [5:0] f);
        if (rem == 0 && m_mdu(v, op, f))
            rem = ((f == F_DIV || f == F_DIVU) ? DIV_LAT : MUL_LAT) + 1;
        else if (rem > 0)
            rem--;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        E_valid = 1'b1; E_op = OP_R; E_funct = F_MULT;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (obs() !== 9'b0) begin
                errors++;
                $display("FAIL reset_hold cyc=%0d got=%b want=%b", i, obs(), 9'b0);
            end
            @(negedge clk);
        end
        rst = 1'b0;
        E_valid = 1'b1; E_op = OP_R; E_funct = F_ADD;
        #1;
        checks++;
        if (obs() !== 9'b0) begin
            errors++;
            $display("FAIL reset_release got=%b want=%b", obs(), 9'b0);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        drive(1, OP_R, F_DIV);
        for (int i = 0; i < 3; i++) drive(1, OP_R, F_ADD);
        checks++;
        if (obs() !== BUSY1) begin
            errors++;
            $display("FAIL reset_mid_busy got=%b want=%b", obs(), BUSY1);
        end
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (obs() !== 9'b0) begin
                errors++;
                $display("FAIL reset_mid_hold cyc=%0d got=%b want=%b", i, obs(), 9'b0);
            end
            @(negedge clk);
        end
        rst = 1'b0;
        for (int i = 0; i < DIV_LAT + 4; i++) begin
            drive(1, OP_R, F_ADD);
            checks++;
            if (obs() !== 9'b0) begin
                errors++;
                $display("FAIL reset_mid_after cyc=%0d got=%b want=%b", i, obs(), 9'b0);
            end
        end
    endtask

    task automatic test_mult();
        logic [8:0] want;
        do_reset();
        drive(1, OP_R, F_MULT);
        checks++;
        if (obs() !== 9'b0000_1010_0) begin
            errors++;
            $display("FAIL mult_launch got=%b want=%b", obs(), 9'b0000_1010_0);
        end
        for (int t = 1; t <= MUL_LAT + 2; t++) begin
            drive(1, OP_R, F_ADD);
            want = (t <= MUL_LAT + 1) ? BUSY1 : 9'b0;
            if (t == MUL_LAT + 1) want |= HWE;
            checks++;
            if (obs() !== want) begin
                errors++;
                $display("FAIL mult_timeline t=%0d got=%b want=%b", t, obs(), want);
            end
        end
    endtask

    task automatic test_divu_mflo();
        logic [8:0] want;
        do_reset();
        drive(1, OP_R, F_DIVU);
        checks++;
        if (obs() !== 9'b0000_1100_0) begin
            errors++;
            $display("FAIL divu_launch got=%b want=%b", obs(), 9'b0000_1100_0);
        end
        for (int t = 1; t <= DIV_LAT + 2; t++) begin
            drive(1, OP_R, F_MFLO);
            want = (t <= DIV_LAT + 1) ? (STALL4 | BUSY1) : 9'b0;
            if (t == DIV_LAT + 1) want |= HWE;
            checks++;
            if (obs() !== want) begin
                errors++;
                $display("FAIL divu_mflo t=%0d got=%b want=%b", t, obs(), want);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [8:0] want;
        do_reset();
        drive(1, OP_R, F_MULTU);
        checks++;
        if (obs() !== 9'b0000_1000_0) begin
            errors++;
            $display("FAIL multu_launch got=%b want=%b", obs(), 9'b0000_1000_0);
        end
        for (int t = 1; t <= MUL_LAT + 2; t++) begin
            drive(1, OP_R, F_DIV);
            if (t <= MUL_LAT + 1) begin
                want = STALL4 | BUSY1;
                if (t == MUL_LAT + 1) want |= HWE;
            end else begin
                want = 9'b0000_1110_0;
            end
            checks++;
            if (obs() !== want) begin
                errors++;
                $display("FAIL back_to_back t=%0d got=%b want=%b", t, obs(), want);
            end
        end
        drive(1, OP_R, F_ADD);
        checks++;
        if (obs() !== BUSY1) begin
            errors++;
            $display("FAIL back_to_back_second_busy got=%b want=%b", obs(), BUSY1);
        end
    endtask

    task automatic test_overlap();
        logic [5:0] ops [4];
        logic [8:0] want;
        ops[0] = OP_R; ops[1] = OP_LW; ops[2] = OP_SW; ops[3] = OP_R;
        do_reset();
        drive(1, OP_R, F_MULT);
        for (int t = 1; t <= 4; t++) begin
            drive(1, ops[t-1], F_ADD);
            checks++;
            if (obs() !== BUSY1) begin
                errors++;
                $display("FAIL overlap t=%0d got=%b want=%b", t, obs(), BUSY1);
            end
        end
        drive(1, OP_R, F_ADD);
        want = BUSY1 | HWE;
        checks++;
        if (obs() !== want) begin
            errors++;
            $display("FAIL overlap_hilo_we got=%b want=%b", obs(), want);
        end
    endtask

    task automatic test_invalid();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(0, OP_R, F_DIV);
            checks++;
            if (obs() !== 9'b0) begin
                errors++;
                $display("FAIL invalid_div cyc=%0d got=%b want=%b", i, obs(), 9'b0);
            end
        end
        drive(1, OP_R, F_MULT);
        for (int i = 0; i < 3; i++) begin
            drive(0, OP_R, F_MFHI);
            checks++;
            if (obs() !== BUSY1) begin
                errors++;
                $display("FAIL invalid_mfhi_busy cyc=%0d got=%b want=%b", i, obs(), BUSY1);
            end
        end
    endtask

    task automatic test_random();
        logic [5:0] fset [10];
        logic       v;
        logic [5:0] op, f;
        logic [8:0] want;
        fset[0] = F_MULT; fset[1] = F_MULTU; fset[2] = F_DIV;  fset[3] = F_DIVU;
        fset[4] = F_MFHI; fset[5] = F_MFLO;  fset[6] = F_MTHI; fset[7] = F_MTLO;
        fset[8] = F_ADD;  fset[9] = 6'h2A;
        do_reset();
        rem = 0;
        for (int i = 0; i < 1500; i++) begin
            v  = ($urandom_range(7) != 0);
            op = ($urandom_range(5) == 0) ? OP_LW : OP_R;
            f  = fset[$urandom_range(9)];
            drive(v, op, f);
            want = m_expect(v, op, f);
            checks++;
            if (obs() !== want) begin
                errors++;
                $display("FAIL random cyc=%0d v=%b op=%h f=%h got=%b want=%b", i, v, op, f, obs(), want);
            end
            if ((obs() & 9'b0000_1000_0) != 0 && (obs() & STALL4) != 0) begin
                errors++;
                $display("FAIL start_with_stall cyc=%0d got=%b want=no overlap", i, obs());
            end
            m_advance(v, op, f);
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid();
        test_mult();
        test_divu_mflo();
        test_back_to_back();
        test_overlap();
        test_invalid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mdu_sequencer.md
# mdu_sequencer

Sequencer and hazard controller for the multi-cycle multiply/divide unit (MDU) and the HI/LO register pair in the 5-stage MIPS pipeline.
- Launches MULT/MULTU/DIV/DIVU from the E stage and counts the fixed MDU latency.
- Pulses the HI/LO write enable when the result is ready.
- Stalls F/D/E and bubbles M while an E-stage instruction needs HI/LO or the MDU before they are available.
- Its stall outputs are ORed with the load-use stall controller outside this block.

## Interface
Parameters:
- MUL_LAT, 4: BUSY cycles for MULT/MULTU (1..63).
- DIV_LAT, 32: BUSY cycles for DIV/DIVU (1..63).

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  reset; asynchronous, active-high.
- E_valid  in  1  the E-stage slot holds a real instruction (0 for a bubble).
- E_op  in  6  E-stage opcode.
- E_funct  in  6  E-stage funct field.
- F_stall  out  1  hold the PC.
- D_stall  out  1  hold the IF/ID register.
- E_stall  out  1  hold the ID/EX register.
- M_bubble  out  1  insert a NOP into EX/MEM.
- mdu_start  out  1  one-cycle launch pulse to the MDU datapath.
- mdu_div  out  1  with mdu_start: 1 = divide, 0 = multiply.
- mdu_signed  out  1  with mdu_start: 1 = MULT/DIV, 0 = MULTU/DIVU.
- hilo_we  out  1  one-cycle write of the MDU result into HI/LO.
- busy  out  1  state is not IDLE.

## Operation
HI/LO-class instruction: E_valid=1, E_op=`IRTYPE, and E_funct in {MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI, MTLO}. MDU-class instruction: the first four of these.

State machine with a 6-bit down-counter `cnt`:
- IDLE
  - On an MDU-class instruction: mdu_start=1 and mdu_div/mdu_signed decoded from funct, all combinationally.
  - Next cycle: cnt <= LAT-1, where LAT is DIV_LAT for divides and MUL_LAT for multiplies; state <= BUSY.
  - No stall is raised for the launching instruction; it leaves E normally.
- BUSY
  - If cnt==0, go to DONE; otherwise cnt <= cnt-1.
  - BUSY therefore lasts exactly LAT cycles.
- DONE
  - hilo_we=1 for exactly this cycle, then IDLE.
  - No launch is possible from DONE.
- Hazard: in BUSY or DONE, a HI/LO-class instruction in E sets F_stall=D_stall=E_stall=M_bubble=1 combinationally.
  - The stalled instruction re-evaluates in the following IDLE cycle. An MDU-class instruction launches then; MFHI/MFLO reads the freshly written HI/LO.
- Non-HI/LO instructions in E never stall. Independent instructions overlap the MDU operation.
- Divide by zero: runs the full DIV_LAT and asserts hilo_we; the HI/LO contents are architecturally undefined.
- All outputs except busy and cnt-driven state are combinational from state and the E inputs. There are no other registered outputs.

## Timing
- Reset: state=IDLE, cnt=0. Every output reads 0 while rst=1, and immediately after rst deasserts if E holds no MDU-class instruction.
- Reset mid-operation: the operation is aborted. No hilo_we follows; HI/LO keeps its previous value.
- Launch in cycle t:
  - BUSY during t+1 .. t+LAT.
  - DONE, with hilo_we=1, at t+LAT+1.
  - An MFHI in E at t+1 stalls t+1 .. t+LAT+1 and proceeds at t+LAT+2.
- Back-to-back MDU ops: the second op stalls until IDLE. Minimum launch spacing is LAT+2 cycles.
- E_valid=0 never launches and never stalls, whatever E_op/E_funct hold.
- mdu_start is never asserted in the same cycle as any stall output.

## Structure
- Add the funct constants FMULT, FMULTU, FDIV, FDIVU, FMFHI, FMFLO, FMTHI, FMTLO to `def.v`, next to `IRTYPE`. Add state encodings SIDLE, SBUSY, SDONE there too; no local magic numbers.
- Single module with no sub-modules. The HI/LO-class and MDU-class decode lives in one combinational always block.
- The top level ORs F_stall/D_stall with the load-use stall controller outputs.

## Test plan
- Reset: rst=1 mid-BUSY for 2 cycles -> state IDLE, all outputs 0, no hilo_we afterwards.
- MULT (MUL_LAT=4) launched at t=0 -> mdu_start=1, mdu_div=0, mdu_signed=1 at t=0; busy t=1..5; hilo_we only at t=5.
- DIVU at t=0, MFLO in E at t=1 -> all four stall outputs =1 for t=1..33; hilo_we at t=33; MFLO proceeds at t=34 with stalls=0.
- MULTU at t=0, DIV in E at t=1 -> stalled t=1..5; DIV launches at t=6 with mdu_div=1, mdu_signed=1.
- MULT at t=0, then ADD/LW/SW in E at t=1..4 -> no stall outputs; hilo_we at t=5.
- E_valid=0 with E_funct=FDIV -> no mdu_start, busy stays 0; same with E_valid=0 and FMFHI during BUSY -> no stall.
